// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared state encoding, instruction types and field offsets
package control_pkg;

    typedef enum logic [2:0] {
        RESET_STATE = 3'd0,
        FETCH_INSTR = 3'd1,
        READ_OPS    = 3'd2,
        EXECUTE     = 3'd3,
        WRITEBACK   = 3'd4
    } state_e;

    localparam logic [1:0] ITYPE_00 = 2'b00;
    localparam logic [1:0] ITYPE_01 = 2'b01;
    localparam logic [1:0] ITYPE_10 = 2'b10;
    localparam logic [1:0] ITYPE_11 = 2'b11;

    localparam logic [7:0] COND_ALWAYS = 8'h3F;

    // Field positions, all measured down from the instruction MSB.
    function automatic int type_lsb(input int instr_w);
        return instr_w - 2;
    endfunction

    function automatic int call_bit(input int instr_w);
        return instr_w - 4;
    endfunction

    function automatic int ret_bit(input int instr_w);
        return instr_w - 5;
    endfunction

    function automatic int inv_bit(input int instr_w);
        return instr_w - 7;
    endfunction

    function automatic int out_bit(input int instr_w);
        return instr_w - 8;
    endfunction

    function automatic int cond_lsb(input int instr_w);
        return instr_w - 16;
    endfunction

endpackage

// File: rtl/control_seq_cond_eval.sv
// rtl/control_seq_cond_eval.sv - combinational branch-condition evaluator
module cond_eval
    import control_pkg::*;
#(
    parameter int NUM_COND = 4
) (
    input  logic [7:0]          cond,
    input  logic                inv,
    input  logic [NUM_COND-1:0] flags,
    output logic                take_branch
);

    logic c;

    // Select the addressed flag; codes beyond NUM_COND read as false,
    // while the always-code overrides the flag lookup entirely.
    always_comb begin
        c = 1'b0;
        for (int i = 0; i < NUM_COND; i++) begin
            if (cond == 8'(i)) begin
                c = flags[i];
            end
        end
        if (cond == COND_ALWAYS) begin
            take_branch = ~inv;
        end else begin
            take_branch = c ^ inv;
        end
    end

endmodule

// File: rtl/control_seq.sv
// rtl/control_seq.sv - instruction-cycle sequencer with fetch/ALU/output handshakes
module control_seq
    import control_pkg::*;
#(
    parameter int INSTR_W  = 32,
    parameter int NUM_COND = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                imem_valid,
    input  logic [INSTR_W-1:0]  imem_data,
    input  logic [NUM_COND-1:0] flags,
    input  logic                exec_done,
    input  logic                out_ready,
    output logic [2:0]          state,
    output logic [INSTR_W-1:0]  crnt_instrn,
    output logic                latch_instr,
    output logic                rd_oprnd_a,
    output logic                rd_oprnd_b,
    output logic                latch_flags,
    output logic                latch_result,
    output logic                write_regc,
    output logic                reset_aluregs,
    output logic                pushenbl,
    output logic                popenbl,
    output logic                out_valid,
    output logic                take_branch,
    output logic                usedata_imm_or_regb,
    output logic                usedata_imm_or_alu,
    output logic                endofinstrn,
    output logic [CNT_W-1:0]    retired
);

    localparam int TYPE_LSB = type_lsb(INSTR_W);
    localparam int CALL_BIT = call_bit(INSTR_W);
    localparam int RET_BIT  = ret_bit(INSTR_W);
    localparam int INV_BIT  = inv_bit(INSTR_W);
    localparam int OUT_BIT  = out_bit(INSTR_W);
    localparam int COND_LSB = cond_lsb(INSTR_W);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] crnt_instrn_q, crnt_instrn_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               usedata_imm_or_regb_q, usedata_imm_or_regb_d;
    logic               usedata_imm_or_alu_q, usedata_imm_or_alu_d;
    logic               endofinstrn_q, endofinstrn_d;

    logic [1:0] itype;
    logic       f_call, f_ret, f_inv, f_out;
    logic [7:0] f_cond;
    logic       cond_take;
    logic       exec_complete;

    logic latch_instr_c, rd_a_c, rd_b_c, latch_flags_c, latch_result_c;
    logic write_regc_c, reset_aluregs_c, pushenbl_c, popenbl_c, out_valid_c;

    assign itype  = crnt_instrn_q[TYPE_LSB +: 2];
    assign f_call = crnt_instrn_q[CALL_BIT];
    assign f_ret  = crnt_instrn_q[RET_BIT];
    assign f_inv  = crnt_instrn_q[INV_BIT];
    assign f_out  = crnt_instrn_q[OUT_BIT];
    assign f_cond = crnt_instrn_q[COND_LSB +: 8];

    cond_eval #(
        .NUM_COND (NUM_COND)
    ) u_cond_eval (
        .cond        (f_cond),
        .inv         (f_inv),
        .flags       (flags),
        .take_branch (cond_take)
    );

    // Only the handshake that matches the instruction type can end EXECUTE.
    always_comb begin
        case (itype)
            ITYPE_01, ITYPE_10: exec_complete = exec_done;
            ITYPE_00:           exec_complete = f_out ? out_ready : 1'b1;
            default:            exec_complete = 1'b1;
        endcase
    end

    // Next-state, strobe and mux-select decode for the current state.
    always_comb begin
        state_d               = state_q;
        crnt_instrn_d         = crnt_instrn_q;
        retired_d             = retired_q;
        usedata_imm_or_regb_d = 1'b0;
        usedata_imm_or_alu_d  = 1'b0;
        endofinstrn_d         = 1'b0;
        latch_instr_c         = 1'b0;
        rd_a_c                = 1'b0;
        rd_b_c                = 1'b0;
        latch_flags_c         = 1'b0;
        latch_result_c        = 1'b0;
        write_regc_c          = 1'b0;
        reset_aluregs_c       = 1'b0;
        pushenbl_c            = 1'b0;
        popenbl_c             = 1'b0;
        out_valid_c           = 1'b0;

        if (state_q == READ_OPS || state_q == EXECUTE || state_q == WRITEBACK) begin
            usedata_imm_or_regb_d = (itype == ITYPE_10);
            usedata_imm_or_alu_d  = (itype == ITYPE_11);
        end

        case (state_q)
            RESET_STATE: begin
                state_d = FETCH_INSTR;
            end
            FETCH_INSTR: begin
                latch_instr_c   = imem_valid;
                reset_aluregs_c = imem_valid;
                if (imem_valid) begin
                    crnt_instrn_d = imem_data;
                    state_d       = READ_OPS;
                end
            end
            READ_OPS: begin
                case (itype)
                    ITYPE_00: rd_a_c = f_out;
                    ITYPE_01: begin rd_a_c = 1'b1; rd_b_c = 1'b1; end
                    ITYPE_10: begin rd_a_c = 1'b1; rd_b_c = 1'b1; end
                    default:  rd_b_c = 1'b1;
                endcase
                state_d = EXECUTE;
            end
            EXECUTE: begin
                out_valid_c = (itype == ITYPE_00) && f_out;
                if (exec_complete) begin
                    pushenbl_c     = (itype == ITYPE_00) && f_call && cond_take;
                    popenbl_c      = (itype == ITYPE_00) && f_ret;
                    latch_flags_c  = (itype == ITYPE_01) || (itype == ITYPE_10);
                    latch_result_c = (itype != ITYPE_00);
                    state_d        = WRITEBACK;
                end
            end
            WRITEBACK: begin
                write_regc_c  = (itype != ITYPE_00);
                retired_d     = retired_q + CNT_W'(1);
                endofinstrn_d = 1'b1;
                state_d       = FETCH_INSTR;
            end
            default: begin
                state_d = FETCH_INSTR;
            end
        endcase
    end

    // All sequencer state; reset aborts any in-flight instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q               <= RESET_STATE;
            crnt_instrn_q         <= '0;
            retired_q             <= '0;
            usedata_imm_or_regb_q <= 1'b0;
            usedata_imm_or_alu_q  <= 1'b0;
            endofinstrn_q         <= 1'b0;
        end else begin
            state_q               <= state_d;
            crnt_instrn_q         <= crnt_instrn_d;
            retired_q             <= retired_d;
            usedata_imm_or_regb_q <= usedata_imm_or_regb_d;
            usedata_imm_or_alu_q  <= usedata_imm_or_alu_d;
            endofinstrn_q         <= endofinstrn_d;
        end
    end

    // Strobes are suppressed while reset is asserted so an aborted
    // instruction never leaks a partial datapath action.
    always_comb begin
        latch_instr   = latch_instr_c   & ~reset;
        rd_oprnd_a    = rd_a_c          & ~reset;
        rd_oprnd_b    = rd_b_c          & ~reset;
        latch_flags   = latch_flags_c   & ~reset;
        latch_result  = latch_result_c  & ~reset;
        write_regc    = write_regc_c    & ~reset;
        reset_aluregs = reset_aluregs_c & ~reset;
        pushenbl      = pushenbl_c      & ~reset;
        popenbl       = popenbl_c       & ~reset;
        out_valid     = out_valid_c     & ~reset;
    end

    assign state               = state_q;
    assign crnt_instrn         = crnt_instrn_q;
    assign retired             = retired_q;
    assign usedata_imm_or_regb = usedata_imm_or_regb_q;
    assign usedata_imm_or_alu  = usedata_imm_or_alu_q;
    assign endofinstrn         = endofinstrn_q;
    assign take_branch         = cond_take;

endmodule
